// File: rtl/shield_enc_arbiter.sv
// Round-robin arbiter that feeds one cache line at a time through an external encryptor and
// HMAC engine, then returns ciphertext plus tag to the owning requester.
module shield_enc_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned LINE_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned TAG_WIDTH     = 128,
  localparam int unsigned IdW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // Requester side
  input  logic [NUM_REQ-1:0]               req_val_i,
  output logic [NUM_REQ-1:0]               req_rdy_o,
  input  logic [NUM_REQ*LINE_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*COUNTER_WIDTH-1:0] req_counter_i,
  input  logic [NUM_REQ*64-1:0]            req_iv_i,
  // Response side
  output logic [LINE_WIDTH-1:0]            resp_data_o,
  output logic [TAG_WIDTH-1:0]             resp_tag_o,
  output logic [IdW-1:0]                   resp_id_o,
  output logic                             resp_val_o,
  input  logic                             resp_rdy_i,
  // Encryptor
  output logic [LINE_WIDTH-1:0]            enc_req_data_o,
  output logic [COUNTER_WIDTH-1:0]         enc_req_counter_o,
  output logic [63:0]                      enc_req_iv_o,
  output logic                             enc_req_val_o,
  input  logic                             enc_req_rdy_i,
  input  logic [LINE_WIDTH-1:0]            enc_resp_data_i,
  input  logic                             enc_resp_val_i,
  // Authentication engine
  output logic                             auth_start_o,
  output logic [COUNTER_WIDTH-1:0]         auth_req_counter_o,
  output logic [ADDR_WIDTH-1:0]            auth_req_addr_o,
  input  logic [TAG_WIDTH-1:0]             auth_resp_tag_i,
  input  logic                             auth_resp_val_i,
  output logic                             auth_resp_rdy_o,
  output logic                             busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StEnc,
    StWaitCt,
    StWaitTag,
    StResp
  } state_e;

  state_e                   state_q, state_d;
  logic [IdW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]           id_q, id_d;
  logic [LINE_WIDTH-1:0]    data_q, data_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [COUNTER_WIDTH-1:0] ctr_q, ctr_d;
  logic [63:0]              iv_q, iv_d;
  logic [LINE_WIDTH-1:0]    ct_q, ct_d;
  logic [TAG_WIDTH-1:0]     tag_q, tag_d;

  logic                     grant_found;
  logic [IdW-1:0]           grant_idx;
  logic [IdW-1:0]           cand;

  // First asserted requester at or after rr_ptr_q, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_val_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    addr_d   = addr_q;
    ctr_d    = ctr_q;
    iv_d     = iv_q;
    ct_d     = ct_q;
    tag_d    = tag_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          state_d  = StEnc;
          rr_ptr_d = IdW'((32'(grant_idx) + 1) % NUM_REQ);
          id_d     = grant_idx;
          data_d   = req_data_i[32'(grant_idx)*LINE_WIDTH +: LINE_WIDTH];
          addr_d   = req_addr_i[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          ctr_d    = req_counter_i[32'(grant_idx)*COUNTER_WIDTH +: COUNTER_WIDTH];
          iv_d     = req_iv_i[32'(grant_idx)*64 +: 64];
        end
      end
      StEnc: begin
        if (enc_req_rdy_i) state_d = StWaitCt;
      end
      StWaitCt: begin
        // Only the first valid beat is taken; later beats are ignored.
        if (enc_resp_val_i) begin
          ct_d    = enc_resp_data_i;
          state_d = StWaitTag;
        end
      end
      StWaitTag: begin
        if (auth_resp_val_i) begin
          tag_d   = auth_resp_tag_i;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_rdy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      ctr_q    <= '0;
      iv_q     <= '0;
      ct_q     <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      ctr_q    <= ctr_d;
      iv_q     <= iv_d;
      ct_q     <= ct_d;
      tag_q    <= tag_d;
    end
  end

  // Gated by rst_n so no requester sees a handshake while reset is held.
  always_comb begin
    req_rdy_o = '0;
    if (rst_n && (state_q == StIdle) && grant_found) begin
      req_rdy_o = NUM_REQ'(1) << grant_idx;
    end
  end

  assign enc_req_data_o     = data_q;
  assign enc_req_counter_o  = ctr_q;
  assign enc_req_iv_o       = iv_q;
  assign enc_req_val_o      = (state_q == StEnc);

  // The encryptor may stall on HMAC readiness, so start stays high through both wait states.
  assign auth_start_o       = (state_q == StWaitCt) || (state_q == StWaitTag);
  assign auth_req_counter_o = ctr_q;
  assign auth_req_addr_o    = addr_q;
  assign auth_resp_rdy_o    = (state_q == StWaitTag);

  assign resp_data_o        = ct_q;
  assign resp_tag_o         = tag_q;
  assign resp_id_o          = id_q;
  assign resp_val_o         = (state_q == StResp);

  assign busy_o             = (state_q != StIdle);

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_rdy_o));
  a_rdy_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
                                    (|req_rdy_o) |-> (state_q == StIdle));

endmodule
